div4: RTL and testbench

DIV4 -- requirements
Module: div4

---
 rtl/div4.sv | 195 +++++++++++++++++++
 tb/tb_div4.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div4.sv
// ============================================================================
// div4 -- sequential unsigned restoring divider (8-bit dividend, 4-bit divisor)
//
// Purpose:
//   Divides z by y and produces quotient q and remainder r. One quotient bit
//   is resolved per RUN cycle, MSB first, using a 5-bit partial remainder.
//   A start pulse accepted in IDLE latches z and y. q/r are published together
//   with a one-cycle done pulse nine edges after the accepting edge. q/r then
//   hold until the next result is published.
//
//   With y = 0 the restoring datapath gives q = all ones and r = z[3:0],
//   because every trial subtraction of zero succeeds.
//
// Optional feature (macro DIV4_DIVZERO_EN):
//   Adds the err output. An accepted start with y = 0 skips RUN. busy is high
//   for one cycle, and done/q/r/err are published two edges after acceptance.
//   err is cleared by the next accepted start and by reset.
//
// Ports:
//   clk    in   1        rising-edge clock
//   rst    in   1        synchronous active-high reset
//   start  in   1        request pulse, honoured only in IDLE
//   z      in   DATA_W   dividend (unsigned)
//   y      in   COEF_W   divisor (unsigned)
//   q      out  DATA_W   quotient, registered
//   r      out  COEF_W   remainder, registered
//   busy   out  1        division in progress
//   done   out  1        one-cycle pulse, q/r valid
//   err    out  1        divide-by-zero flag (only with DIV4_DIVZERO_EN)
// ============================================================================
module div4 #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] z,
    input  logic [COEF_W-1:0] y,
    output logic [DATA_W-1:0] q,
    output logic [COEF_W-1:0] r,
    output logic              busy,
    output logic              done
`ifdef DIV4_DIVZERO_EN
    ,
    output logic              err
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // Working registers. They are reloaded on every accepted start, so they
    // need no reset.
    logic [DATA_W-1:0] dvd;   // remaining dividend bits, MSB consumed first
    logic [COEF_W-1:0] dvs;   // latched divisor
    logic [COEF_W-1:0] rem;   // partial remainder (always < dvs when dvs != 0)
    logic [DATA_W-1:0] quo;   // quotient bits collected so far
    logic [CNT_W-1:0]  cnt;   // iterations completed in RUN

`ifdef DIV4_DIVZERO_EN
    logic [1:0]        zwait; // divide-by-zero publish countdown held in DONE
`endif

    logic              accept;
    logic              iterate;
    logic [COEF_W:0]   stp;   // {quotient bit, next partial remainder}

    // One restoring step: shift the next dividend bit into the partial
    // remainder, then subtract the divisor if it fits. If the subtraction
    // does not fit, the shifted value is already below the divisor, so its
    // low COEF_W bits are exact. With a zero divisor the subtraction always
    // fits and the truncation keeps the low bits of the shifted value.
    function automatic logic [COEF_W:0] restore_step(
        input logic [COEF_W-1:0] rem_in,
        input logic              bit_in,
        input logic [COEF_W-1:0] dvs_in
    );
        logic [COEF_W:0] pr;
        logic [COEF_W:0] diff;
        pr   = {rem_in, bit_in};
        diff = pr - {1'b0, dvs_in};
        if (pr >= {1'b0, dvs_in})
            restore_step = {1'b1, diff[COEF_W-1:0]};
        else
            restore_step = {1'b0, pr[COEF_W-1:0]};
    endfunction

    assign accept  = (state == IDLE) && start;
    assign iterate = (state == RUN) && (cnt != CNT_W'(DATA_W));
    assign stp     = restore_step(rem, dvd[DATA_W-1], dvs);

    // Datapath: operand capture and one restoring iteration per RUN cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            dvd <= z;
            dvs <= y;
            rem <= '0;
            quo <= '0;
        end else if (iterate) begin
            dvd <= {dvd[DATA_W-2:0], 1'b0};
            rem <= stp[COEF_W-1:0];
            quo <= {quo[DATA_W-2:0], stp[COEF_W]};
        end
    end

    // Control FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef DIV4_DIVZERO_EN
            zwait <= 2'd0;
            err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        cnt  <= '0;
`ifdef DIV4_DIVZERO_EN
                        err  <= 1'b0;
                        if (y == '0) begin
                            state <= DONE;
                            zwait <= 2'd2;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end

                RUN: begin
                    // The publishing cycle follows the last iteration, which
                    // keeps busy high through edge k+8 and places done at k+9.
                    if (cnt == CNT_W'(DATA_W)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        q     <= quo;
                        r     <= rem;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
`ifdef DIV4_DIVZERO_EN
                    // The divide-by-zero shortcut waits here: busy drops
                    // after one cycle, and the result is published one
                    // edge later.
                    if (zwait == 2'd2) begin
                        zwait <= 2'd1;
                        busy  <= 1'b0;
                    end else if (zwait == 2'd1) begin
                        zwait <= 2'd0;
                        done  <= 1'b1;
                        q     <= '1;
                        r     <= dvd[COEF_W-1:0];
                        err   <= 1'b1;
                    end else begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
`else
                    state <= IDLE;
                    done  <= 1'b0;
`endif
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div4.sv
// ============================================================================
// tb_div4 -- self-checking bench for div4
//
// Uses directed vectors, hand-written multi-cycle sequences, randomized
// divisions and an exhaustive sweep. A plain-arithmetic reference model
// (z / y, z % y) supplies the expected quotient and remainder.
// ============================================================================
module tb_div4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] z;
    logic [3:0] y;
    logic [7:0] q;
    logic [3:0] r;
    logic       busy;
    logic       done;
`ifdef DIV4_DIVZERO_EN
    logic       err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    div4 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .z     (z),
        .y     (y),
        .q     (q),
        .r     (r),
        .busy  (busy),
`ifdef DIV4_DIVZERO_EN
        .done  (done),
        .err   (err)
`else
        .done  (done)
`endif
    );

    typedef struct {
        logic [7:0] z;
        logic [3:0] y;
        logic [7:0] q;
        logic [3:0] r;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: ordinary unsigned division, plus the zero-divisor result.
    function automatic void model(input logic [7:0] zi, input logic [3:0] yi,
                                  output logic [7:0] qo, output logic [3:0] ro);
        int zn, yn, qn, rn;
        zn = int'(zi);
        yn = int'(yi);
        if (yn == 0) begin
            qo = 8'hFF;
            ro = zi[3:0];
        end else begin
            qn = zn / yn;
            rn = zn % yn;
            qo = qn[7:0];
            ro = rn[3:0];
        end
    endfunction

    // Runs one division that starts at edge k. The task checks busy/done
    // timing, that q/r stay stable until done, the result itself, and that
    // done lasts exactly one cycle.
    task automatic run_div(input logic [7:0] zi, input logic [3:0] yi,
                           input logic [7:0] eq, input logic [3:0] er, input string tag);
        int         exp_lat;
        int         busy_last;
        int         tbad;
        logic [7:0] qp;
        logic [3:0] rp;
        exp_lat   = 9;
        busy_last = 8;
`ifdef DIV4_DIVZERO_EN
        if (yi == 4'd0) begin
            exp_lat   = 2;
            busy_last = 0;
        end
`endif
        @(negedge clk);
        z     = zi;
        y     = yi;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        z     = 8'($urandom);
        y     = 4'($urandom);
        qp    = q;
        rp    = r;
        tbad  = 0;
        for (int lat = 0; lat <= exp_lat; lat++) begin
            if (lat > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy !== ((lat <= busy_last) ? 1'b1 : 1'b0)) tbad++;
            if (done !== ((lat == exp_lat) ? 1'b1 : 1'b0)) tbad++;
            if (busy === 1'b1 && done === 1'b1) tbad++;
            if (lat < exp_lat && (q !== qp || r !== rp)) tbad++;
        end
        check({tag, " timing"}, tbad, 0);
        check({tag, " q"}, q, eq);
        check({tag, " r"}, r, er);
`ifdef DIV4_DIVZERO_EN
        check({tag, " err"}, err, (yi == 4'd0) ? 1 : 0);
`endif
        @(posedge clk);
        #1;
        check({tag, " done pulse width"}, done, 0);
    endtask

    initial begin
        vec_t       tbl[5];
        logic [7:0] eq;
        logic [3:0] er;
        logic [7:0] zr;
        logic [3:0] yr;
        logic [7:0] qd;
        logic [3:0] rd;
        int         ndone;
        int         done_at;
        int         nbusy;

        tbl[0] = '{z: 8'h37, y: 4'h5, q: 8'h0B, r: 4'h0};
        tbl[1] = '{z: 8'hD2, y: 4'hE, q: 8'h0F, r: 4'h0};
        tbl[2] = '{z: 8'hE1, y: 4'hF, q: 8'h0F, r: 4'h0};
        tbl[3] = '{z: 8'h64, y: 4'h7, q: 8'h0E, r: 4'h2};
        tbl[4] = '{z: 8'hFF, y: 4'h1, q: 8'hFF, r: 4'h0};

        rst   = 1'b1;
        start = 1'b1;
        z     = 8'hAA;
        y     = 4'h3;
        repeat (3) @(posedge clk);
        #1;
        check("reset q", q, 0);
        check("reset r", r, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
`ifdef DIV4_DIVZERO_EN
        check("reset err", err, 0);
`endif
        start = 1'b0;
        rst   = 1'b0;

        // Directed vectors
        for (int i = 0; i < 5; i++)
            run_div(tbl[i].z, tbl[i].y, tbl[i].q, tbl[i].r, $sformatf("vec%0d", i));

        // Start re-pulsed with new operands at edge k+3 is ignored
        @(negedge clk);
        z = 8'h82; y = 4'hD; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; z = 8'hFF; y = 4'h1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        ndone   = 0;
        done_at = -1;
        qd      = 8'h00;
        rd      = 4'h0;
        for (int i = 4; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = i;
                    qd = q;
                    rd = r;
                end
            end
        end
        check("restart done count", ndone, 1);
        check("restart done edge", done_at, 9);
        check("restart q", qd, 8'h0A);
        check("restart r", rd, 4'h0);

        // Reset at edge k+4 aborts the division
        @(negedge clk);
        z = 8'hC7; y = 4'h3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort q", q, 0);
        check("abort r", r, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        ndone = 0;
        nbusy = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
            if (busy === 1'b1) nbusy++;
        end
        check("abort no done", ndone, 0);
        check("abort no busy", nbusy, 0);
        run_div(8'h30, 4'h4, 8'h0C, 4'h0, "post-reset");

        // Divide by zero
        run_div(8'h5A, 4'h0, 8'hFF, 4'hA, "divzero");
`ifdef DIV4_DIVZERO_EN
        repeat (4) @(posedge clk);
        #1;
        check("err hold", err, 1);
`endif
        run_div(8'h64, 4'h7, 8'h0E, 4'h2, "after divzero");

        // Randomized divisions, divisor may be zero
        for (int i = 0; i < 60; i++) begin
            zr = 8'($urandom);
            yr = 4'($urandom_range(0, 15));
            model(zr, yr, eq, er);
            run_div(zr, yr, eq, er, $sformatf("rand z=%0h y=%0h", zr, yr));
        end

        // Exhaustive sweep over all nonzero divisors
        for (int zi = 0; zi < 256; zi++) begin
            for (int yi = 1; yi < 16; yi++) begin
                zr = 8'(zi);
                yr = 4'(yi);
                model(zr, yr, eq, er);
                run_div(zr, yr, eq, er, $sformatf("sweep z=%0h y=%0h", zr, yr));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
